// File: rtl/rgb_led_scheduler_if.sv
// rgb_led_scheduler_if
//   Groups the request side (req/color/bright) and the LED/status side
//   (LED_R/G/B, grant, busy) of the RGB LED scheduler into one bundle.
//   master : the requesters / driver side (drives req, color, bright)
//   slave  : the scheduler itself (drives LEDs, grant, busy)
//   req    [3:0]  per-requester LED request, bit i = requester i
//   color  [11:0] requester i color at [3i+2:3i], ordered {B,G,R}
//   bright [7:0]  global PWM duty, sampled at grant
//   LED_R/G/B     active-low LED drive (1 = off)
//   grant  [3:0]  one-hot current owner, 0 when nobody owns the LED
//   busy          high while showing or in the dark gap
interface rgb_led_scheduler_if;
  logic [3:0]  req;
  logic [11:0] color;
  logic [7:0]  bright;
  logic        LED_R;
  logic        LED_G;
  logic        LED_B;
  logic [3:0]  grant;
  logic        busy;

  modport master (
    output req, color, bright,
    input  LED_R, LED_G, LED_B, grant, busy
  );

  modport slave (
    input  req, color, bright,
    output LED_R, LED_G, LED_B, grant, busy
  );
endinterface

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler
//   Time-shares one RGB LED between four requesters. A round-robin winner
//   owns the LED for SLOT_CYCLES (or until it drops its request), showing
//   its latched 3-bit color at the latched PWM brightness; every grant is
//   followed by GAP_CYCLES of darkness before the next arbitration.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    rgb_led_scheduler_if.slave (req/color/bright in,
//            LED_R/G/B, grant, busy out)
//   All outputs come straight from flops (or from the state register for
//   busy), so there is no combinational path from the request inputs.

// One LED channel: a registered active-low drive. The flop is fed from the
// next-cycle values of state/color/brightness/PWM so that the registered
// output matches the current cycle's state without an extra cycle of lag.
module rgb_led_scheduler_chan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       show_d,
  input  logic       col_bit_d,
  input  logic [7:0] pwm_d,
  input  logic [7:0] bright_d,
  output logic       led_q
);
  logic led_d;

  always_comb begin
    led_d = ~(show_d & col_bit_d & (pwm_d < bright_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 1'b1;
    else        led_q <= led_d;
  end
endmodule

module rgb_led_scheduler #(
  parameter int unsigned SLOT_CYCLES = 12000000,
  parameter int unsigned GAP_CYCLES  = 1200000
) (
  input  logic              clk,
  input  logic              rst_n,
  rgb_led_scheduler_if.slave bus
);
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        last_q,  last_d;
  logic [2:0]        col_q,   col_d;
  logic [7:0]        bright_q, bright_d;
  logic [7:0]        pwm_q,   pwm_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [3:0] col_base;
  logic       do_grant;
  logic       show_d;
  logic [2:0] led_q;

  // Round-robin search last+1 .. last+4 (mod 4). Walking k downwards lets
  // the nearest requester overwrite farther ones, so the closest wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[last_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = last_q + 2'(k);
      end
    end
  end

  assign col_base = {2'b00, win_idx} * 4'd3;

  // Next-state / datapath. While in SHOW the owner index is last_q, since
  // last_q is updated with the winner at the moment of grant.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    col_d    = col_q;
    bright_d = bright_q;
    slot_d   = slot_q;
    gap_d    = gap_q;
    pwm_d    = pwm_q + 8'd1;
    do_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) do_grant = 1'b1;
      end
      SHOW: begin
        if ((slot_q == '0) || !bus.req[last_q]) begin
          state_d = GAP;
          grant_d = 4'b0000;
          slot_d  = '0;
          gap_d   = GAP_LOAD;
        end else begin
          slot_d = slot_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (win_vld) do_grant = 1'b1;
          else         state_d  = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase

    // Grant is common to the IDLE and end-of-GAP paths.
    if (do_grant) begin
      state_d  = SHOW;
      grant_d  = 4'b0001 << win_idx;
      last_d   = win_idx;
      col_d    = bus.color[col_base +: 3];
      bright_d = bus.bright;
      slot_d   = SLOT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      last_q   <= 2'd3;   // requester 0 gets first priority after reset
      col_q    <= 3'b000;
      bright_q <= 8'd0;
      pwm_q    <= 8'd0;
      slot_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      col_q    <= col_d;
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
      slot_q   <= slot_d;
      gap_q    <= gap_d;
    end
  end

  assign show_d = (state_d == SHOW);

  // Channel 0 = R, 1 = G, 2 = B, matching the {B,G,R} color ordering.
  for (genvar c = 0; c < 3; c++) begin : g_chan
    rgb_led_scheduler_chan u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .show_d    (show_d),
      .col_bit_d (col_d[c]),
      .pwm_d     (pwm_d),
      .bright_d  (bright_d),
      .led_q     (led_q[c])
    );
  end

  assign bus.LED_R = led_q[0];
  assign bus.LED_G = led_q[1];
  assign bus.LED_B = led_q[2];
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_rgb_led_scheduler.sv
// tb_rgb_led_scheduler
//   Drives the scheduler with SLOT_CYCLES=16, GAP_CYCLES=4. A behavioural
//   model tracks owner / elapsed show time / remaining gap time / PWM phase
//   as plain integers; a compare process checks every DUT output against it
//   at each falling edge. Directed scenarios add literal expectations, then
//   a randomized phase exercises arbitration, drops and resets.
module tb_rgb_led_scheduler;
  localparam int SLOT = 16;
  localparam int GAP  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rgb_led_scheduler_if bus ();

  rgb_led_scheduler #(.SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_owner  = -1;  // -1: nobody owns the LED
  int         m_shown  = 0;   // edges spent in the current show
  int         m_gap    = 0;   // dark cycles still to go
  int         m_last   = 3;
  int         m_pwm    = 0;
  logic [2:0] m_col    = 3'b000;
  int         m_bright = 0;

  task automatic pick();
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last + k) % 4;
      if (bus.req[i] && m_owner < 0) begin
        m_owner  = i;
        m_last   = i;
        m_col    = 3'((bus.color >> (3 * i)) & 12'h7);
        m_bright = int'(bus.bright);
        m_shown  = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_shown = 0; m_gap = 0; m_last = 3;
      m_pwm = 0; m_col = 3'b000; m_bright = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 256;
      if (m_owner >= 0) begin
        m_shown++;
        if (m_shown == SLOT || !bus.req[m_owner]) begin
          m_owner = -1;
          m_gap   = GAP;
        end
      end else begin
        if (m_gap > 0) m_gap--;
        if (m_gap == 0) pick();
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [3:0] e_grant;
      logic       e_busy;
      logic [2:0] e_led;
      e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e_busy  = (m_owner >= 0) || (m_gap > 0);
      for (int x = 0; x < 3; x++)
        e_led[x] = !((m_owner >= 0) && m_col[x] && (m_pwm < m_bright));
      chk("model_grant", 32'(bus.grant), 32'(e_grant));
      chk("model_busy",  32'(bus.busy),  32'(e_busy));
      chk("model_led",   32'({bus.LED_B, bus.LED_G, bus.LED_R}), 32'(e_led));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asserts reset away from the clock edges, holds 3 cycles, releases at a
  // falling edge with the given request applied.
  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    bus.req = r;
    rst_n   = 1'b1;
  endtask

  initial begin
    int         lo_r, hi_gb, lo_any, lo_g, lo_b, n2;
    logic [3:0] prev;
    logic [3:0] seq[$];
    logic [3:0] rr_exp[5];

    bus.req = 4'b0000; bus.color = 12'h000; bus.bright = 8'd0;
    tick(2);
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_busy",  32'(bus.busy),  32'h0);
    chk("reset_led",   32'({bus.LED_B, bus.LED_G, bus.LED_R}), 32'h7);
    tick(1);

    // Sole requester 0, red at full brightness.
    bus.req = 4'b0001; bus.color = 12'h001; bus.bright = 8'd255;
    rst_n = 1'b1;
    tick(1);
    chk("solo_grant_first", 32'(bus.grant), 32'h1);
    chk("solo_busy", 32'(bus.busy), 32'h1);
    lo_r = 0; hi_gb = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i > 0) tick(1);
      lo_r  += int'(!bus.LED_R);
      hi_gb += int'(bus.LED_G & bus.LED_B);
    end
    chk("solo_red_on_cycles", 32'(lo_r), 32'd16);
    chk("solo_gb_off_cycles", 32'(hi_gb), 32'd16);
    tick(1);
    chk("solo_gap_grant", 32'(bus.grant), 32'h0);
    tick(GAP);
    chk("solo_regrant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    tick(12);

    // All four requesting from reset: strict rotation 0,1,2,3,0.
    bus.color = 12'($urandom); bus.bright = 8'($urandom_range(1, 255));
    do_reset(4'b1111);
    prev = 4'b0000; n2 = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.grant != 4'b0000 && bus.grant != prev) seq.push_back(bus.grant);
      if (bus.grant == 4'b0010) n2++;
      prev = bus.grant;
    end
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rr_count", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("rr_seq", 32'(seq[i]), 32'(rr_exp[i]));
    chk("rr_show_len", 32'(n2), 32'd16);

    // Owner 2 drops its request early; next in rotation after 2 is 3.
    do_reset(4'b0100);
    tick(1);
    chk("drop_grant", 32'(bus.grant), 32'h4);
    tick(4);
    bus.req = 4'b1001;
    tick(1);
    chk("drop_gap", 32'(bus.grant), 32'h0);
    tick(GAP);
    chk("drop_next", 32'(bus.grant), 32'h8);
    bus.req = 4'b0000;
    tick(30);

    // Zero brightness keeps every channel dark.
    bus.req = 4'b0001; bus.color = 12'h007; bus.bright = 8'd0;
    tick(1);
    chk("dark_grant", 32'(bus.grant), 32'h1);
    lo_any = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i > 0) tick(1);
      lo_any += int'(!bus.LED_R) + int'(!bus.LED_G) + int'(!bus.LED_B);
    end
    chk("dark_led_on", 32'(lo_any), 32'd0);
    bus.req = 4'b0000;
    tick(25);

    // Color changes mid-show are ignored until the next grant.
    bus.req = 4'b0010; bus.color = 12'h010; bus.bright = 8'd255;
    tick(1);
    lo_g = 0; lo_b = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i > 0) tick(1);
      if (i == 5) bus.color = 12'h020;
      lo_g += int'(!bus.LED_G);
      lo_b += int'(!bus.LED_B);
    end
    chk("latch_g_on", 32'(lo_g >= 15), 32'd1);
    chk("latch_b_off", 32'(lo_b), 32'd0);
    bus.req = 4'b0000;
    tick(25);

    // Asynchronous reset mid-show.
    bus.req = 4'b0001; bus.color = 12'h007; bus.bright = 8'd255;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_grant", 32'(bus.grant), 32'h0);
    chk("areset_busy",  32'(bus.busy),  32'h0);
    chk("areset_led",   32'({bus.LED_B, bus.LED_G, bus.LED_R}), 32'h7);
    repeat (3) @(negedge clk);
    bus.req = 4'b0100;
    rst_n = 1'b1;
    tick(1);
    chk("areset_regrant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    tick(25);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if ($urandom_range(0, 7) == 0)   bus.req    = 4'($urandom);
      if ($urandom_range(0, 3) == 0)   bus.color  = 12'($urandom);
      if ($urandom_range(0, 3) == 0)   bus.bright = 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset(4'($urandom));
    end

    tick(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_led_scheduler.md
RGB_LED_SCHEDULER -- requirements
Module: rgb_led_scheduler

Interface
REQ-001 Parameter SLOT_CYCLES, default 12000000, clock cycles one requester owns the LED (1 s at 12 MHz).
REQ-002 Parameter GAP_CYCLES, default 1200000, clock cycles the LED is dark between grants.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester LED request; bit i is requester i.
REQ-006 color  input  12  requester i color at bits [3i+2:3i], ordered {B,G,R}.
REQ-007 bright  input  8  global PWM duty, sampled at grant.
REQ-008 LED_R, LED_G, LED_B  output  1 each  active-low RGB drive (1 = off).
REQ-009 grant  output  4  one-hot current owner; all-zero when no owner.
REQ-010 busy  output  1  high in SHOW or GAP.

Function
REQ-011 The FSM SHALL have states IDLE, SHOW and GAP.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with grant=0 and all LEDs off.
REQ-013 In IDLE with req!=0, the block SHALL enter SHOW on the next edge, with grant one-hot for the winner in that same cycle (1-cycle latency).
REQ-014 Arbitration SHALL be round-robin: search order last+1, last+2, last+3, last (mod 4), where last is the most recently granted index.
REQ-015 At grant, the block SHALL latch the winner's 3-bit color and bright, then load a slot counter with SLOT_CYCLES-1.
REQ-016 Input changes during SHOW SHALL NOT alter the latched color or brightness.
REQ-017 In SHOW, the slot counter SHALL decrement each cycle.
REQ-018 SHOW SHALL go to GAP when the slot counter reaches 0 (exactly SLOT_CYCLES cycles in SHOW).
REQ-019 SHOW SHALL go to GAP early on the cycle after req[owner] is sampled low.
REQ-020 On entering GAP, grant SHALL clear to 0, LEDs SHALL go off, and a gap counter SHALL load GAP_CYCLES-1.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles.
REQ-022 At the end of GAP, the block SHALL arbitrate as in IDLE, entering SHOW directly if req!=0 and IDLE otherwise.
REQ-023 An 8-bit PWM counter SHALL free-run from 0 to 255 and wrap to 0.
REQ-024 In SHOW, channel X SHALL be on (LED_X=0) iff latched color bit X==1 and pwm_cnt < latched bright.
REQ-025 bright=0 SHALL give always off; bright=255 SHALL give 255 of every 256 cycles on.
REQ-026 The LED outputs and grant SHALL be registered (no combinational path from inputs).
REQ-027 A sole requester that holds req high SHALL be re-granted after each GAP.
REQ-028 A request arriving during GAP SHALL be considered at GAP end; no request is queued beyond its req level.

Reset
REQ-029 While rst_n=0, the block SHALL be in state IDLE, with grant=0, busy=0, LED_R=LED_G=LED_B=1, pwm_cnt=0, and both counters at 0.
REQ-030 On reset, last SHALL be 3, so that requester 0 has first priority after reset.
REQ-031 rst_n asserted mid-SHOW SHALL turn LEDs off and clear grant immediately, without waiting for a clock edge.

Verification (SLOT_CYCLES=16, GAP_CYCLES=4)
REQ-032 req=4'b0001, color[2:0]=3'b001, bright=255 -> one cycle later grant=0001, busy=1, LED_R low on 255 of 256 cycles, G/B high; after 16 cycles grant=0, then after 4 more grant=0001 again.
REQ-033 req=4'b1111 held for 100 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with each SHOW lasting 16 cycles and separated by 4 dark cycles.
REQ-034 Owner 2 drops req[2] at cycle 5 of SHOW -> next cycle GAP starts with grant=0; after 4 cycles the next requester is granted in rotation.
REQ-035 bright=0 with color=3'b111 granted -> all LEDs stay high for the entire SHOW.
REQ-036 color changed from 3'b010 to 3'b100 mid-SHOW -> LED_G keeps pulsing and LED_B stays high until the next grant.
REQ-037 rst_n pulled low mid-SHOW for 3 cycles, then released with req=4'b0100 -> outputs off asynchronously; after release, grant=0100 one cycle later.
